grf_mp: RTL and testbench
=========================

# grf_mp

Parametrised multi-port general register file for the pipelined CPU, the successor to the single-write, two-read D-stage GRF. It provides NUM_RD combinational read ports and two write ports with byte enables. It also provides optional write-to-read bypass and a per-register pending-write scoreboard, so the hazard unit can stall on multi-cycle producers such as mult/div. It sits in the D stage: reads serve decode, write port 0 is driven by W, and write port 1 by the mult/div writeback path.

## Interface
- DATA_W, 32, register width in bits; a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports; range 1..4.
- BYPASS, 1, 1 enables same-cycle write-to-read forwarding of data and busy; 0 disables it.

- clk  in  1  clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; same packing as rd_addr.
- rd_busy  out  NUM_RD  1 = the addressed register has an outstanding issued write.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr0_be  in  DATA_W/8  write port 0 byte enables.
- wr1_en, wr1_addr, wr1_data, wr1_be  in  same widths as port 0  write port 1.
- iss_en  in  1  marks a register busy (a long-latency producer has been issued).
- iss_addr  in  ADDR_W  register to mark busy.

## Operation
- Storage: DEPTH x DATA_W data array plus a DEPTH-bit busy vector.
- Register 0:
  - always reads 0 and never reads busy;
  - writes and issues to address 0 are discarded.
- Write effect: a write with wrN_en=1 and at least one be bit set updates only the enabled byte lanes.
- Write effect with be = 0: no data change, but it still clears busy for that address.
- Both ports writing the same address in one cycle:
  - merged per byte lane; wr0 wins each lane where wr0_be is set;
  - a lane enabled only by wr1_be takes wr1 data;
  - a lane enabled by neither keeps its old value.
- Busy update at each posedge, in priority order:
  - reset clears all busy bits;
  - else iss_en sets busy[iss_addr];
  - else any write (wr0 or wr1) to an address clears its busy bit.
- Issue and write to the same address in the same cycle: busy ends set, because the new issue supersedes the write. Data is still written.
- Reads are combinational and equal the array contents, modified by bypass as below.
- BYPASS=1, read address equal to a same-cycle write address (nonzero):
  - rd_data shows the merged post-write value;
  - rd_busy shows the post-update busy value (0 unless a same-cycle issue targets the same address).
- BYPASS=0: reads show pre-edge state only.
- Reset behaviour:
  - all DEPTH registers and all busy bits clear in the single reset cycle;
  - writes and issues presented during reset are ignored;
  - reset asserted mid-operation discards all outstanding busy state.

## Timing
- Write latency: data is visible through the array one cycle after the posedge; visible in the same cycle through bypass when BYPASS=1.
- Busy latency: a busy bit set by iss_en reads 1 from the cycle after issue.
- Read paths: zero latency, purely combinational from rd_addr and the write/issue inputs; no handshake.
- Outputs during and after reset:
  - rd_data = 0 for every address from the cycle after reset;
  - rd_busy = 0 for every address from the cycle after reset.
- Power-up: the array and busy vector initialise to 0 for simulation.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via wr0 with be=4'hF, then read r5 on port 1 -> 0xDEADBEEF; after another reset, r5 reads 0.
- Write r3 = 0x11223344, then wr1 to r3 with be=4'b0101 and data 0xAABBCCDD -> r3 = 0x11BB33DD.
- Same cycle: wr0 r7 = 0x000000FF with be=4'b0001, and wr1 r7 = 0xFFFFFF00 with be=4'b1111 -> r7 = 0xFFFFFFFF. With BYPASS=1, a same-cycle read of r7 also returns 0xFFFFFFFF.
- Issue r9 -> rd_busy=1 on the next cycle; wr1 to r9 with be=0 -> busy cleared. A same-cycle issue plus write to r9 -> busy stays 1.
- Write 0x12345678 to r0 and issue r0 -> reads return 0, rd_busy=0.
- BYPASS=0 build: a same-cycle write of 0x5 to r4 over 0x1 -> read returns 0x1, then 0x5 the next cycle.

Source files
------------

// File: rtl/grf_mp_if.sv
// rtl/grf_mp_if.sv - read, write and issue bundle of the multi-port register file
// master drives addresses/writes/issues; slave (the register file) returns read data and busy.
interface grf_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic [DATA_W/8-1:0]      wr0_be;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic [DATA_W/8-1:0]      wr1_be;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr0_be,
    output wr1_en, wr1_addr, wr1_data, wr1_be, iss_en, iss_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr0_be,
    input  wr1_en, wr1_addr, wr1_data, wr1_be, iss_en, iss_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/grf_mp.sv
// rtl/grf_mp.sv - multi-port GRF with byte-enable writes, bypass and pending-write scoreboard
// Register 0 is hardwired to zero and never busy; wr0 wins byte lanes over wr1.
module grf_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic      clk,
  input  logic      reset,
  grf_mp_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic [DATA_W-1:0] w_mem_nxt [DEPTH];
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_iss;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  // Writes and issues are squashed during reset and when they target r0.
  assign w_wr0 = bus.wr0_en & ~reset & (bus.wr0_addr != '0);
  assign w_wr1 = bus.wr1_en & ~reset & (bus.wr1_addr != '0);
  assign w_iss = bus.iss_en & ~reset & (bus.iss_addr != '0);

  always_comb begin : p_next
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i]  = r_mem[i];
      w_busy_nxt[i] = r_busy[i];
    end
    for (int i = 1; i < DEPTH; i++) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wr0 && bus.wr0_addr == ADDR_W'(i) && bus.wr0_be[b])
          w_mem_nxt[i][b*8 +: 8] = bus.wr0_data[b*8 +: 8];
        else if (w_wr1 && bus.wr1_addr == ADDR_W'(i) && bus.wr1_be[b])
          w_mem_nxt[i][b*8 +: 8] = bus.wr1_data[b*8 +: 8];
      end
      // Any write, even with all byte enables low, retires the pending producer.
      if ((w_wr0 && bus.wr0_addr == ADDR_W'(i)) || (w_wr1 && bus.wr1_addr == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b0;
      if (w_iss && bus.iss_addr == ADDR_W'(i))
        w_busy_nxt[i] = 1'b1;
    end
    w_mem_nxt[0]  = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_nxt[i];
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin : p_read
    logic [ADDR_W-1:0] w_a;
    logic              w_hit;
    w_rd_data = '0;
    w_rd_busy = '0;
    w_a       = '0;
    w_hit     = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_a   = bus.rd_addr[k*ADDR_W +: ADDR_W];
      w_hit = (BYPASS != 0) &&
              ((w_wr0 && bus.wr0_addr == w_a) || (w_wr1 && bus.wr1_addr == w_a));
      if (w_a != '0) begin
        w_rd_data[k*DATA_W +: DATA_W] = w_hit ? w_mem_nxt[w_a]  : r_mem[w_a];
        w_rd_busy[k]                  = w_hit ? w_busy_nxt[w_a] : r_busy[w_a];
      end
    end
  end

  assign bus.rd_data = w_rd_data;
  assign bus.rd_busy = w_rd_busy;
endmodule

// File: tb/tb_grf_mp.sv
// tb/tb_grf_mp.sv - scoreboard bench for grf_mp, bypass and non-bypass builds side by side
// Both builds see identical stimulus; a behavioural model predicts each build's reads.
module tb_grf_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] t_rd_addr;
  logic             t_wr0_en, t_wr1_en, t_iss_en;
  logic [AW-1:0]    t_wr0_addr, t_wr1_addr, t_iss_addr;
  logic [DW-1:0]    t_wr0_data, t_wr1_data;
  logic [DW/8-1:0]  t_wr0_be, t_wr1_be;

  grf_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus1 ();
  grf_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();

  assign bus1.rd_addr  = t_rd_addr;  assign bus0.rd_addr  = t_rd_addr;
  assign bus1.wr0_en   = t_wr0_en;   assign bus0.wr0_en   = t_wr0_en;
  assign bus1.wr0_addr = t_wr0_addr; assign bus0.wr0_addr = t_wr0_addr;
  assign bus1.wr0_data = t_wr0_data; assign bus0.wr0_data = t_wr0_data;
  assign bus1.wr0_be   = t_wr0_be;   assign bus0.wr0_be   = t_wr0_be;
  assign bus1.wr1_en   = t_wr1_en;   assign bus0.wr1_en   = t_wr1_en;
  assign bus1.wr1_addr = t_wr1_addr; assign bus0.wr1_addr = t_wr1_addr;
  assign bus1.wr1_data = t_wr1_data; assign bus0.wr1_data = t_wr1_data;
  assign bus1.wr1_be   = t_wr1_be;   assign bus0.wr1_be   = t_wr1_be;
  assign bus1.iss_en   = t_iss_en;   assign bus0.iss_en   = t_iss_en;
  assign bus1.iss_addr = t_iss_addr; assign bus0.iss_addr = t_iss_addr;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  typedef struct {
    bit               chk;
    logic [NR*DW-1:0] d1, d0;
    logic [NR-1:0]    b1, b0;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  task automatic idle();
    t_rd_addr = '0;
    t_wr0_en = 0; t_wr0_addr = '0; t_wr0_data = '0; t_wr0_be = '0;
    t_wr1_en = 0; t_wr1_addr = '0; t_wr1_data = '0; t_wr1_be = '0;
    t_iss_en = 0; t_iss_addr = '0;
  endtask

  task automatic rd(input int a1, input int a0);
    t_rd_addr = {5'(a1), 5'(a0)};
  endtask

  // Predict this cycle's reads, queue them, then advance the model across the edge.
  task automatic step(input bit chk);
    logic [31:0] n_mem [32];
    logic [31:0] n_busy;
    exp_t        e;
    bit          h0, h1, hit;
    int          a;
    n_mem  = m_mem;
    n_busy = m_busy;
    if (reset) begin
      for (int i = 0; i < 32; i++) n_mem[i] = 0;
      n_busy = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        h0 = t_wr0_en && (t_wr0_addr == 5'(r));
        h1 = t_wr1_en && (t_wr1_addr == 5'(r));
        for (int l = 0; l < 4; l++) begin
          if (h0 && t_wr0_be[l])      n_mem[r][l*8 +: 8] = t_wr0_data[l*8 +: 8];
          else if (h1 && t_wr1_be[l]) n_mem[r][l*8 +: 8] = t_wr1_data[l*8 +: 8];
        end
        if (h0 || h1) n_busy[r] = 1'b0;
        if (t_iss_en && t_iss_addr == 5'(r)) n_busy[r] = 1'b1;
      end
    end
    e.chk = chk;
    for (int k = 0; k < NR; k++) begin
      a   = int'(t_rd_addr[k*AW +: AW]);
      hit = !reset && a != 0 &&
            ((t_wr0_en && t_wr0_addr == 5'(a)) || (t_wr1_en && t_wr1_addr == 5'(a)));
      e.d0[k*DW +: DW] = (a == 0) ? 32'h0 : m_mem[a];
      e.b0[k]          = (a == 0) ? 1'b0  : m_busy[a];
      e.d1[k*DW +: DW] = hit ? n_mem[a]  : e.d0[k*DW +: DW];
      e.b1[k]          = hit ? n_busy[a] : e.b0[k];
    end
    q.push_back(e);
    @(posedge clk);
    m_mem  = n_mem;
    m_busy = n_busy;
    #1;
  endtask

  task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          chk_val("bypass_rd_data",  64'(bus1.rd_data), 64'(e.d1));
          chk_val("bypass_rd_busy",  64'(bus1.rd_busy), 64'(e.b1));
          chk_val("nobypass_rd_data", 64'(bus0.rd_data), 64'(e.d0));
          chk_val("nobypass_rd_busy", 64'(bus0.rd_busy), 64'(e.b0));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [4:0] pick_addr();
    return ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin : stim
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_busy = 0;
    idle();
    reset = 1;
    @(posedge clk); #1;
    step(0);
    reset = 0;

    idle(); rd(5, 5); step(1);
    idle(); t_wr0_en = 1; t_wr0_addr = 5; t_wr0_data = 32'hDEADBEEF; t_wr0_be = 4'hF; rd(5, 5); step(1);
    idle(); rd(5, 0); step(1);
    idle(); reset = 1; t_wr0_en = 1; t_wr0_addr = 6; t_wr0_data = 32'h55; t_wr0_be = 4'hF;
    t_iss_en = 1; t_iss_addr = 6; rd(5, 6); step(0);
    reset = 0; idle(); rd(5, 6); step(1);

    idle(); t_wr0_en = 1; t_wr0_addr = 3; t_wr0_data = 32'h11223344; t_wr0_be = 4'hF; step(1);
    idle(); t_wr1_en = 1; t_wr1_addr = 3; t_wr1_data = 32'hAABBCCDD; t_wr1_be = 4'b0101; rd(3, 3); step(1);
    idle(); rd(3, 0); step(1);

    idle(); t_wr0_en = 1; t_wr0_addr = 7; t_wr0_data = 32'h000000FF; t_wr0_be = 4'b0001;
    t_wr1_en = 1; t_wr1_addr = 7; t_wr1_data = 32'hFFFFFF00; t_wr1_be = 4'hF; rd(7, 7); step(1);
    idle(); rd(0, 7); step(1);

    idle(); t_iss_en = 1; t_iss_addr = 9; rd(9, 9); step(1);
    idle(); rd(9, 9); step(1);
    idle(); t_wr1_en = 1; t_wr1_addr = 9; t_wr1_data = 32'hCAFE0000; t_wr1_be = 4'h0; rd(9, 9); step(1);
    idle(); rd(9, 9); step(1);
    idle(); t_iss_en = 1; t_iss_addr = 9; t_wr0_en = 1; t_wr0_addr = 9; t_wr0_data = 32'h1;
    t_wr0_be = 4'hF; rd(9, 9); step(1);
    idle(); rd(9, 9); step(1);
    idle(); t_iss_en = 1; t_iss_addr = 10; step(1);
    idle(); reset = 1; rd(10, 9); step(0);
    reset = 0; idle(); rd(10, 9); step(1);

    idle(); t_wr0_en = 1; t_wr0_addr = 0; t_wr0_data = 32'h12345678; t_wr0_be = 4'hF;
    t_iss_en = 1; t_iss_addr = 0; rd(0, 0); step(1);
    idle(); rd(0, 0); step(1);

    idle(); t_wr0_en = 1; t_wr0_addr = 4; t_wr0_data = 32'h1; t_wr0_be = 4'hF; step(1);
    idle(); t_wr0_en = 1; t_wr0_addr = 4; t_wr0_data = 32'h5; t_wr0_be = 4'hF; rd(4, 4); step(1);
    idle(); rd(4, 4); step(1);

    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom % 50 == 0);
      t_rd_addr  = {pick_addr(), pick_addr()};
      t_wr0_en   = $urandom % 2;  t_wr0_addr = pick_addr();
      t_wr0_data = $urandom;      t_wr0_be   = 4'($urandom);
      t_wr1_en   = $urandom % 2;  t_wr1_addr = pick_addr();
      t_wr1_data = $urandom;      t_wr1_be   = 4'($urandom);
      t_iss_en   = ($urandom % 3 == 0); t_iss_addr = pick_addr();
      step(!reset);
    end
    reset = 0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
